// File: rtl/fetch_if.sv
// Fetch-stage bus bundle: instruction memory port, control inputs from
// execute, and the decode-facing valid/ready output with its fetch counter.
//   imem_addr/imem_instr   : combinational instruction memory access
//   halt/redirect/redirect_pc : fetch control from the pipeline
//   out_valid/out_ready/out_instr/out_pc : buffer head towards decode
//   fetch_count            : number of words pushed into the buffer
// master = fetch controller side, slave = memory/pipeline side.
interface fetch_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        halt;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] fetch_count;

  modport master (
    output imem_addr,
    input  imem_instr,
    input  halt,
    input  redirect,
    input  redirect_pc,
    output out_valid,
    input  out_ready,
    output out_instr,
    output out_pc,
    output fetch_count
  );

  modport slave (
    input  imem_addr,
    output imem_instr,
    output halt,
    output redirect,
    output redirect_pc,
    input  out_valid,
    output out_ready,
    input  out_instr,
    input  out_pc,
    input  fetch_count
  );
endinterface

// File: rtl/fetch_controller.sv
// Instruction fetch controller with a 2-entry {pc, instr} buffer.
// Ports:
//   clk   : clock, all state changes on the rising edge
//   rst_n : asynchronous active-low reset
//   bus   : fetch_if.master (memory port, halt/redirect, decode handshake,
//           fetch_count)
// Parameters:
//   RESET_PC  : first fetch address after reset
//   NOP_INSTR : instruction presented when the buffer is empty
module fetch_controller #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'hE1A0_0000
) (
  input  logic     clk,
  input  logic     rst_n,
  fetch_if.master  bus
);

  typedef enum logic [1:0] {StStart, StFetch, StHalted} state_e;

  // pc low bits are kept zero by masking every value written into pc_q.
  localparam logic [31:0] PcMask = 32'hFFFF_FFFC;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [1:0]  count_q, count_d;
  logic [31:0] fetch_count_q, fetch_count_d;
  // Entry 0 is always the head; entry 1 is the one behind it.
  logic [31:0] e0_pc_q, e0_pc_d, e0_instr_q, e0_instr_d;
  logic [31:0] e1_pc_q, e1_pc_d, e1_instr_q, e1_instr_d;

  logic redirect_take;
  logic pop;
  logic push;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StStart;
      pc_q          <= RESET_PC & PcMask;
      count_q       <= 2'd0;
      fetch_count_q <= 32'd0;
      e0_pc_q       <= 32'd0;
      e0_instr_q    <= 32'd0;
      e1_pc_q       <= 32'd0;
      e1_instr_q    <= 32'd0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      count_q       <= count_d;
      fetch_count_q <= fetch_count_d;
      e0_pc_q       <= e0_pc_d;
      e0_instr_q    <= e0_instr_d;
      e1_pc_q       <= e1_pc_d;
      e1_instr_q    <= e1_instr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StStart:  state_d = StFetch;
      StFetch:  state_d = bus.halt ? StHalted : StFetch;
      StHalted: state_d = bus.halt ? StHalted : StFetch;
      default:  state_d = StStart;
    endcase
  end

  // Redirect is ignored during the START cycle; elsewhere it flushes the
  // buffer and overrides both pop and push.
  assign redirect_take = bus.redirect && (state_q != StStart);
  assign pop  = (count_q != 2'd0) && bus.out_ready && !redirect_take;
  assign push = (state_q == StFetch) && !bus.halt && !bus.redirect &&
                ((count_q != 2'd2) || pop);

  always_comb begin
    pc_d          = pc_q;
    count_d       = count_q;
    fetch_count_d = fetch_count_q;
    e0_pc_d       = e0_pc_q;
    e0_instr_d    = e0_instr_q;
    e1_pc_d       = e1_pc_q;
    e1_instr_d    = e1_instr_q;

    if (redirect_take) begin
      count_d = 2'd0;
      pc_d    = bus.redirect_pc & PcMask;
    end else begin
      if (push) begin
        pc_d          = (pc_q + 32'd4) & PcMask;
        fetch_count_d = fetch_count_q + 32'd1;
      end
      unique case ({push, pop})
        2'b10: begin
          if (count_q == 2'd0) begin
            e0_pc_d    = pc_q;
            e0_instr_d = bus.imem_instr;
          end else begin
            e1_pc_d    = pc_q;
            e1_instr_d = bus.imem_instr;
          end
          count_d = count_q + 2'd1;
        end
        2'b01: begin
          e0_pc_d    = e1_pc_q;
          e0_instr_d = e1_instr_q;
          count_d    = count_q - 2'd1;
        end
        2'b11: begin
          // Occupancy unchanged; new word lands behind whatever remains.
          if (count_q == 2'd1) begin
            e0_pc_d    = pc_q;
            e0_instr_d = bus.imem_instr;
          end else begin
            e0_pc_d    = e1_pc_q;
            e0_instr_d = e1_instr_q;
            e1_pc_d    = pc_q;
            e1_instr_d = bus.imem_instr;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.imem_addr   = pc_q;
  assign bus.out_valid   = (count_q != 2'd0);
  assign bus.out_instr   = (count_q != 2'd0) ? e0_instr_q : NOP_INSTR;
  assign bus.out_pc      = (count_q != 2'd0) ? e0_pc_q : 32'd0;
  assign bus.fetch_count = fetch_count_q;

endmodule

// File: tb/tb_fetch_controller.sv
// Bench for fetch_controller: directed phases push expected fetch addresses
// into a scoreboard queue; a negedge monitor pops and compares every word
// accepted by decode. Direct checks cover reset, counters, pc and flushes.
module tb_fetch_controller;
  localparam logic [31:0] Nop = 32'hE1A0_0000;
  localparam logic [31:0] Key = 32'hA5A5_0000;

  logic clk;
  logic rst_n;
  fetch_if bus ();

  fetch_controller #(
    .RESET_PC  (32'h0000_0000),
    .NOP_INSTR (Nop)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  assign bus.imem_instr = bus.imem_addr ^ Key;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare each accepted word against the scoreboard.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready && !bus.redirect) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL unexpected_word: got pc %h required none", bus.out_pc);
      end else begin
        logic [31:0] epc;
        epc = exp_q.pop_front();
        check("sb_pc", bus.out_pc, epc);
        check("sb_instr", bus.out_instr, epc ^ Key);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    bus.halt = 1'b0;
    bus.redirect = 1'b0;
    bus.redirect_pc = 32'd0;
    bus.out_ready = 1'b1;
    #2;
    check("rst_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_instr", bus.out_instr, Nop);
    check("rst_pc", bus.out_pc, 32'd0);
    check("rst_fcount", bus.fetch_count, 32'd0);
    check("rst_addr", bus.imem_addr, 32'd0);
    tick();
    rst_n = 1'b1;

    // Free run.
    exp_q.push_back(32'h0); exp_q.push_back(32'h4); exp_q.push_back(32'h8);
    tick();
    check("fr_start_valid", {31'd0, bus.out_valid}, 32'd0);
    check("fr_start_fcount", bus.fetch_count, 32'd0);
    tick();
    check("fr_pc0", bus.out_pc, 32'h0);
    check("fr_instr0", bus.out_instr, 32'hA5A5_0000);
    check("fr_fcount1", bus.fetch_count, 32'd1);
    tick();
    check("fr_pc4", bus.out_pc, 32'h4);
    check("fr_fcount2", bus.fetch_count, 32'd2);
    tick();
    check("fr_pc8", bus.out_pc, 32'h8);
    check("fr_fcount3", bus.fetch_count, 32'd3);
    tick();
    check("fr_pcc", bus.out_pc, 32'hC);
    check("fr_instrc", bus.out_instr, 32'hA5A5_000C);
    check("fr_fcount4", bus.fetch_count, 32'd4);
    check("fr_drained", exp_q.size(), 32'd0);

    // Backpressure from reset.
    rst_n = 1'b0;
    bus.out_ready = 1'b0;
    #1;
    check("bp_rst_valid", {31'd0, bus.out_valid}, 32'd0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    check("bp_head", bus.out_pc, 32'h0);
    check("bp_valid", {31'd0, bus.out_valid}, 32'd1);
    check("bp_addr", bus.imem_addr, 32'h8);
    check("bp_fcount", bus.fetch_count, 32'd2);
    exp_q.push_back(32'h0); exp_q.push_back(32'h4); exp_q.push_back(32'h8);
    bus.out_ready = 1'b1;
    tick();
    check("bp_pc4", bus.out_pc, 32'h4);
    tick();
    check("bp_pc8", bus.out_pc, 32'h8);
    tick();
    check("bp_pcc", bus.out_pc, 32'hC);
    check("bp_fcount5", bus.fetch_count, 32'd5);
    bus.out_ready = 1'b0;
    check("bp_drained", exp_q.size(), 32'd0);

    // Redirect with a full buffer; out_ready in the redirect cycle is ignored.
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h0000_0043;
    bus.out_ready = 1'b1;
    exp_q.push_back(32'h40);
    tick();
    bus.redirect = 1'b0;
    bus.out_ready = 1'b0;
    check("rd_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rd_addr", bus.imem_addr, 32'h40);
    check("rd_fcount", bus.fetch_count, 32'd5);
    tick();
    check("rd_pc40", bus.out_pc, 32'h40);
    check("rd_fcount6", bus.fetch_count, 32'd6);
    tick();
    check("rd_full_head", bus.out_pc, 32'h40);
    check("rd_addr48", bus.imem_addr, 32'h48);
    check("rd_fcount7", bus.fetch_count, 32'd7);

    // Halt drains the full buffer without fetching.
    bus.halt = 1'b1;
    bus.out_ready = 1'b1;
    exp_q.push_back(32'h44);
    tick();
    check("h_pc44", bus.out_pc, 32'h44);
    tick();
    check("h_valid", {31'd0, bus.out_valid}, 32'd0);
    check("h_instr", bus.out_instr, Nop);
    check("h_pc", bus.out_pc, 32'h0);
    check("h_addr", bus.imem_addr, 32'h48);
    check("h_fcount", bus.fetch_count, 32'd7);
    tick();
    check("h_addr_frozen", bus.imem_addr, 32'h48);
    check("h_fcount_frozen", bus.fetch_count, 32'd7);
    check("h_drained", exp_q.size(), 32'd0);
    bus.halt = 1'b0;
    exp_q.push_back(32'h48);
    tick();
    check("h_resume_gap", {31'd0, bus.out_valid}, 32'd0);
    tick();
    check("h_resume_pc", bus.out_pc, 32'h48);
    check("h_resume_fcount", bus.fetch_count, 32'd8);
    bus.halt = 1'b1;
    tick();
    check("h2_valid", {31'd0, bus.out_valid}, 32'd0);
    check("h2_addr", bus.imem_addr, 32'h4C);

    // Redirect while halted.
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h100;
    tick();
    bus.redirect = 1'b0;
    check("hr_addr", bus.imem_addr, 32'h100);
    check("hr_valid", {31'd0, bus.out_valid}, 32'd0);
    check("hr_fcount", bus.fetch_count, 32'd8);
    bus.halt = 1'b0;
    exp_q.push_back(32'h100);
    tick();
    check("hr_gap", {31'd0, bus.out_valid}, 32'd0);
    tick();
    check("hr_pc100", bus.out_pc, 32'h100);
    check("hr_fcount9", bus.fetch_count, 32'd9);

    // Wrap-around; the 0x100 word is flushed by this redirect.
    exp_q.delete();
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'hFFFF_FFFC;
    exp_q.push_back(32'hFFFF_FFFC); exp_q.push_back(32'h0);
    tick();
    bus.redirect = 1'b0;
    check("w_addr", bus.imem_addr, 32'hFFFF_FFFC);
    check("w_valid", {31'd0, bus.out_valid}, 32'd0);
    tick();
    check("w_pc_top", bus.out_pc, 32'hFFFF_FFFC);
    check("w_instr_top", bus.out_instr, 32'h5A5A_FFFC);
    check("w_fcount10", bus.fetch_count, 32'd10);
    tick();
    check("w_pc0", bus.out_pc, 32'h0);
    check("w_addr4", bus.imem_addr, 32'h4);
    tick();
    check("w_pc4", bus.out_pc, 32'h4);
    check("w_fcount12", bus.fetch_count, 32'd12);
    bus.out_ready = 1'b0;
    tick();
    check("w_addrc", bus.imem_addr, 32'hC);

    // Reset between edges with a full buffer.
    #2;
    check("mr_valid_before", {31'd0, bus.out_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("mr_valid", {31'd0, bus.out_valid}, 32'd0);
    check("mr_instr", bus.out_instr, Nop);
    check("mr_pc", bus.out_pc, 32'h0);
    check("mr_fcount", bus.fetch_count, 32'd0);
    check("mr_addr", bus.imem_addr, 32'h0);
    check("mr_drained", exp_q.size(), 32'd0);
    tick();
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    exp_q.push_back(32'h0);
    tick();
    check("mr_start_valid", {31'd0, bus.out_valid}, 32'd0);
    tick();
    check("mr_first_pc", bus.out_pc, 32'h0);
    check("mr_fcount1", bus.fetch_count, 32'd1);
    tick();
    check("end_drained", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule

// File: doc/fetch_controller.md
FETCH_CONTROLLER -- requirements
Module: fetch_controller

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 SHALL have parameter NOP_INSTR, default 32'hE1A0_0000, meaning the value driven on out_instr when the buffer is empty.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on the rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port imem_addr, output, 32, the byte address presented to the combinational instruction memory.
REQ-006 SHALL have port imem_instr, input, 32, the instruction word returned combinationally for imem_addr.
REQ-007 SHALL have port halt, input, 1; when high, no new fetches are issued.
REQ-008 SHALL have port redirect, input, 1, a branch-taken pulse from execute.
REQ-009 SHALL have port redirect_pc, input, 32, the branch target, sampled when redirect=1.
REQ-010 SHALL have port out_valid, output, 1; high when the buffer head is valid.
REQ-011 SHALL have port out_ready, input, 1, the decode-stage accept signal.
REQ-012 SHALL have port out_instr, output, 32, the buffer-head instruction.
REQ-013 SHALL have port out_pc, output, 32, the buffer-head fetch address.
REQ-014 SHALL have port fetch_count, output, 32, the count of words pushed into the buffer.

Function
REQ-015 SHALL implement a 3-state FSM: START (one cycle after reset, no fetch) -> FETCH; FETCH -> HALTED when halt=1; HALTED -> FETCH when halt=0.
REQ-016 SHALL hold the fetch pointer pc, drive imem_addr=pc combinationally, and force pc[1:0]=2'b00 at all times.
REQ-017 SHALL contain a 2-entry FIFO of {pc, instr} pairs with a 2-bit occupancy count (0..2).
REQ-018 SHALL perform a pop when out_valid && out_ready.
REQ-019 SHALL perform a push, in state FETCH with halt=0 and redirect=0, when count<2 or a pop occurs in the same cycle. A push writes {pc, imem_instr}, sets pc<=pc+4 and increments fetch_count.
REQ-020 SHALL, on a simultaneous push and pop, leave count unchanged and keep FIFO order; at count=2 with a pop, push the new word behind the remaining entry.
REQ-021 SHALL, when count=2 and no pop, issue no fetch and hold pc.
REQ-022 SHALL, when redirect=1 in any state other than START, set count<=0, set pc<={redirect_pc[31:2],2'b00}, and perform no push or pop-dependent update that cycle. out_ready in that cycle is ignored.
REQ-023 SHALL give redirect priority over halt: the pc update happens even in HALTED, and the FSM state is still chosen by halt.
REQ-024 SHALL let the FIFO drain in HALTED (pops permitted, no pushes).
REQ-025 SHALL drive out_valid = (count!=0); out_instr/out_pc = head entry when valid, otherwise NOP_INSTR/32'h0.
REQ-026 SHALL wrap pc from 32'hFFFF_FFFC to 32'h0000_0000 and fetch_count from 2^32-1 to 0, with no flag.
REQ-027 SHALL give one-cycle fetch latency: a word pushed at edge N is visible on out_* after edge N.

Reset
REQ-028 SHALL, while rst_n=0 (asynchronously), set state=START, pc=RESET_PC, count=0, fetch_count=0, out_valid=0, out_instr=NOP_INSTR, out_pc=0.
REQ-029 SHALL abandon any in-progress operation on reset assertion mid-operation, with all buffer contents discarded.
REQ-030 SHALL, on the first edge after deassertion, go START->FETCH with no push; the first push at RESET_PC occurs on the second edge.

Verification
REQ-031 SHALL be checked for free-run: out_ready=1, halt=0, memory word at addr A = A ^ 32'hA5A5_0000. Required: out_pc sequence 0,4,8,C on consecutive cycles after the START cycle, out_instr matching, fetch_count incrementing by 1 per cycle.
REQ-032 SHALL be checked for backpressure: out_ready=0 for 5 cycles from reset. Required: count saturates at 2, out_pc holds 0x0, pc holds 0x8, fetch_count=2. Then out_ready=1 yields 0x0, 0x4, 0x8 in order with no gap.
REQ-033 SHALL be checked for redirect: with the buffer full, pulse redirect with redirect_pc=32'h0000_0043. Required: out_valid=0 the next cycle, then out_pc=0x40, and the stale entries never appear.
REQ-034 SHALL be checked for halt: assert halt with count=2, out_ready=1. Required: two words drain, then out_valid=0 and out_instr=NOP_INSTR, with pc and fetch_count frozen. Deasserting halt resumes fetching from the frozen pc.
REQ-035 SHALL be checked for redirect during halt and for wrap-around: a redirect to 0x100 while HALTED, then release, gives first out_pc=0x100. A redirect to 0xFFFF_FFFC gives out_pc 0xFFFF_FFFC then 0x0.
REQ-036 SHALL be checked for mid-operation reset: assert rst_n=0 between edges with count=2. Required: out_valid drops immediately, and after release the first out_pc=RESET_PC.
